// File: rtl/wb_dest_router.sv
// Write-back router: steers the ALU result to reg A, reg B or data memory (req/ack), or drops it.
// Optional WB_TIMEOUT_EN macro aborts a memory write that waits TIMEOUT cycles without mem_ack.
module wb_dest_router #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [1:0]       dest_sel,
    input  logic [WIDTH-1:0] mem_addr_in,
    output logic             regA_we,
    output logic             regB_we,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             wb_done,
    output logic             wb_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state;

    // A zero timeout would leave the wait counter with nothing to count to.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("wb_dest_router: TIMEOUT must be at least 1");
    end

    assign busy = (state == MEM_WAIT);

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tcnt;
    logic          timeout_hit;

    // Counter holds the number of wait edges already seen without ack.
    assign timeout_hit = (tcnt == CW'(TIMEOUT - 1));
`else
    assign wb_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            regA_we   <= 1'b0;
            regB_we   <= 1'b0;
            reg_wdata <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_done   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            wb_err    <= 1'b0;
            tcnt      <= '0;
`endif
        end else begin
            regA_we <= 1'b0;
            regB_we <= 1'b0;
            wb_done <= 1'b0;
`ifdef WB_TIMEOUT_EN
            wb_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wb_valid) begin
                        case (dest_sel)
                            2'b00: begin
                                regA_we   <= 1'b1;
                                reg_wdata <= alu_out;
                                wb_done   <= 1'b1;
                            end
                            2'b01: begin
                                regB_we   <= 1'b1;
                                reg_wdata <= alu_out;
                                wb_done   <= 1'b1;
                            end
                            2'b10: begin
                                mem_req   <= 1'b1;
                                mem_addr  <= mem_addr_in;
                                mem_wdata <= alu_out;
                                state     <= MEM_WAIT;
`ifdef WB_TIMEOUT_EN
                                tcnt      <= '0;
`endif
                            end
                            default: wb_done <= 1'b1;
                        endcase
                    end
                end
                MEM_WAIT: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        wb_done <= 1'b1;
                        state   <= IDLE;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        wb_err  <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dest_router.sv
// Self-checking bench for wb_dest_router: directed scenarios then random traffic against a transaction model.
// Timeout scenarios are compiled in only when WB_TIMEOUT_EN is defined.
module tb_wb_dest_router;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 4;
`ifdef WB_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wb_valid;
    logic [W-1:0] alu_out;
    logic [1:0]   dest_sel;
    logic [W-1:0] mem_addr_in;
    logic         regA_we, regB_we, mem_req, mem_ack, busy, wb_done, wb_err;
    logic [W-1:0] reg_wdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    wb_dest_router #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .alu_out(alu_out),
        .dest_sel(dest_sel), .mem_addr_in(mem_addr_in), .regA_we(regA_we),
        .regB_we(regB_we), .reg_wdata(reg_wdata), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .wb_done(wb_done), .wb_err(wb_err)
    );

    int tests = 0;
    int fails = 0;

    // Model: expected outputs plus the number of edges a memory write has waited.
    logic         e_a, e_b, e_req, e_done, e_err;
    logic [W-1:0] e_rdata, e_addr, e_wdata;
    int           e_wait;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_a = 0; e_b = 0; e_req = 0; e_done = 0; e_err = 0;
        e_rdata = '0; e_addr = '0; e_wdata = '0; e_wait = 0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        e_a = 0; e_b = 0; e_done = 0; e_err = 0;
        if (e_req) begin
            e_wait++;
            if (mem_ack) begin
                e_req = 0; e_done = 1;
            end else if (TEN && e_wait == int'(TO)) begin
                e_req = 0; e_err = 1;
            end
        end else if (wb_valid) begin
            if (dest_sel == 2'd0) begin e_a = 1; e_rdata = alu_out; e_done = 1; end
            else if (dest_sel == 2'd1) begin e_b = 1; e_rdata = alu_out; e_done = 1; end
            else if (dest_sel == 2'd2) begin e_req = 1; e_addr = mem_addr_in; e_wdata = alu_out; e_wait = 0; end
            else e_done = 1;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".regA_we"},   W'(regA_we),  W'(e_a));
        check({ph, ".regB_we"},   W'(regB_we),  W'(e_b));
        check({ph, ".reg_wdata"}, reg_wdata,    e_rdata);
        check({ph, ".mem_req"},   W'(mem_req),  W'(e_req));
        check({ph, ".busy"},      W'(busy),     W'(e_req));
        check({ph, ".mem_addr"},  mem_addr,     e_addr);
        check({ph, ".mem_wdata"}, mem_wdata,    e_wdata);
        check({ph, ".wb_done"},   W'(wb_done),  W'(e_done));
        check({ph, ".wb_err"},    W'(wb_err),   W'(e_err));
    endtask

    task automatic cycle(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [W-1:0] data,
                         input logic [W-1:0] addr, input logic ack);
        wb_valid = v; dest_sel = d; alu_out = data; mem_addr_in = addr; mem_ack = ack;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, '0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Register A write
        drive(1'b1, 2'd0, 8'h3C, 8'h00, 1'b0);
        cycle("regA");
        check("regA.strobe", W'(regA_we), 8'h01);
        check("regA.data", reg_wdata, 8'h3C);

        // Back-to-back reg B then discard
        drive(1'b1, 2'd1, 8'hA5, 8'h00, 1'b0);
        cycle("regB");
        check("regB.strobe", W'(regB_we), 8'h01);
        drive(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);
        cycle("none");
        check("none.hold", reg_wdata, 8'hA5);
        check("none.done", W'(wb_done), 8'h01);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        cycle("idle");

        // Memory write with ack on the third wait edge; a reg request is held meanwhile
        drive(1'b1, 2'd2, 8'h77, 8'h10, 1'b0);
        cycle("mem3.acc");
        check("mem3.addr", mem_addr, 8'h10);
        drive(1'b1, 2'd0, 8'h11, 8'h00, 1'b0);
        cycle("mem3.w1");
        cycle("mem3.w2");
        check("mem3.busy", W'(busy), 8'h01);
        mem_ack = 1'b1;
        cycle("mem3.ack");
        check("mem3.done", W'(wb_done), 8'h01);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        cycle("mem3.post");

        // Ack already high on the first wait edge, then an immediate new request
        drive(1'b1, 2'd2, 8'h5A, 8'h20, 1'b1);
        cycle("mem1.acc");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
        cycle("mem1.ack");
        check("mem1.req", W'(mem_req), 8'h00);
        drive(1'b1, 2'd0, 8'h42, 8'h00, 1'b0);
        cycle("mem1.next");
        check("mem1.next_data", reg_wdata, 8'h42);

        // Asynchronous reset while a memory write is pending
        drive(1'b1, 2'd2, 8'h99, 8'h30, 1'b0);
        cycle("rst.acc");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("rst.after1");
        cycle("rst.after2");

`ifdef WB_TIMEOUT_EN
        // No ack: write is abandoned after TO wait edges
        drive(1'b1, 2'd2, 8'hC3, 8'h40, 1'b0);
        cycle("to.acc");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < int'(TO); i++) cycle("to.wait");
        check("to.err", W'(wb_err), 8'h01);
        cycle("to.post");

        // Ack on the timeout edge wins
        drive(1'b1, 2'd2, 8'h3E, 8'h41, 1'b0);
        cycle("toack.acc");
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < int'(TO) - 1; i++) cycle("toack.wait");
        mem_ack = 1'b1;
        cycle("toack.edge");
        check("toack.done", W'(wb_done), 8'h01);
        mem_ack = 1'b0;
        cycle("toack.post");
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
                  W'($urandom), ($urandom_range(0, 9) < 3));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_dest_router.md
Name: wb_dest_router

Overview:
- Write-back router: the return path from the ALU output to the storage elements that feed the operand muxes.
- Takes the 8-bit ALU result and a 2-bit destination select. Routes the result to register A, register B or data memory, or discards it.
- Register writes complete in one registered cycle. Data-memory writes use a req/ack handshake, and the router stalls upstream until the write completes.

Parameters:
- WIDTH, 8, data and address width in bits.
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack (used only with WB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_valid  input  1  write-back request this cycle.
- alu_out  input  WIDTH  result to write.
- dest_sel  input  2  00 = reg A, 01 = reg B, 10 = data memory, 11 = none (Z).
- mem_addr_in  input  WIDTH  memory address, used when dest_sel = 10.
- regA_we  output  1  one-cycle write strobe to reg A.
- regB_we  output  1  one-cycle write strobe to reg B.
- reg_wdata  output  WIDTH  data for the register writes.
- mem_req  output  1  data-memory write request.
- mem_addr  output  WIDTH  data-memory address.
- mem_wdata  output  WIDTH  data-memory write data.
- mem_ack  input  1  memory accepted the write.
- busy  output  1  router cannot accept; upstream holds its request.
- wb_done  output  1  one-cycle pulse when a write-back (any destination) completes.
- wb_err  output  1  one-cycle pulse on memory timeout (constant 0 without WB_TIMEOUT_EN).

Behaviour:
- Reset (async, rst_n = 0): state = IDLE. All of the following are 0 and a pending memory write is dropped:
  - regA_we, regB_we, mem_req, wb_done, wb_err
  - reg_wdata, mem_addr, mem_wdata
- States: IDLE, MEM_WAIT.
- busy = (state == MEM_WAIT), combinational.
- Acceptance: only in IDLE, when wb_valid = 1 at a rising edge. While busy, wb_valid is ignored; upstream must hold it.
- Accept with dest 00 or 01:
  - Next cycle: regA_we or regB_we = 1 for exactly one cycle, reg_wdata = captured alu_out, wb_done = 1.
  - Latency is 1 cycle. Back-to-back accepts are allowed, so the strobes may stay high on consecutive cycles.
- Accept with dest 11: no strobe. wb_done = 1 next cycle; nothing is written.
- Accept with dest 10:
  - Capture alu_out into mem_wdata and mem_addr_in into mem_addr.
  - Next cycle: mem_req = 1 and state = MEM_WAIT.
  - mem_addr and mem_wdata stay stable while mem_req = 1.
- MEM_WAIT:
  - mem_ack is sampled on each rising edge.
  - On an edge with mem_ack = 1: mem_req = 0, wb_done = 1 for one cycle, state = IDLE. The router can accept a new request on the edge after that one.
  - Minimum memory write: mem_req high 1 cycle when ack arrives on the first edge.
- mem_ack while IDLE: ignored.
- reg_wdata holds its last value when no strobe is active.
- Exactly one of regA_we, regB_we, mem_req-rising, or a silent wb_done occurs per accepted request.
- Reset asserted mid-MEM_WAIT: mem_req drops immediately (async). No wb_done; no retry after reset.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined:
  - A cycle counter, width ceil(log2(TIMEOUT+1)), clears on entering MEM_WAIT and increments each cycle in MEM_WAIT.
  - If it reaches TIMEOUT with no ack: mem_req = 0, state = IDLE, wb_err = 1 for one cycle, no wb_done.
  - If ack and timeout coincide on the same edge, ack wins (wb_done, no wb_err).
- Undefined: no counter; MEM_WAIT waits indefinitely; wb_err tied 0.

Test Plan:
- Reset then wb_valid with alu_out = 8'h3C, dest = 00 -> next cycle regA_we = 1, reg_wdata = 8'h3C, wb_done = 1; regB_we = 0, mem_req = 0.
- Consecutive cycles: dest 01 with 8'hA5, then dest 11 with 8'hFF -> regB_we pulse with 8'hA5, then wb_done only, no strobe; reg_wdata stays 8'hA5.
- dest 10, addr 8'h10, data 8'h77; mem_ack delayed 3 cycles -> mem_req high 3 cycles with addr 8'h10, data 8'h77; busy high throughout; a wb_valid with dest 00 during busy produces no strobe; wb_done one cycle after ack.
- dest 10 with mem_ack already high on the first MEM_WAIT edge -> mem_req high exactly 1 cycle; a new request is accepted the next cycle.
- rst_n pulled low while mem_req = 1 -> mem_req = 0 asynchronously; after release, no wb_done and state is IDLE.
- With WB_TIMEOUT_EN, TIMEOUT = 4, and no ack -> mem_req drops after 4 cycles, wb_err pulses once, no wb_done. Repeat with ack on the 4th edge -> wb_done, no wb_err.
